// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl: round sequencer for the SHA-2 compression datapath.
// Accepts one message block per handshake, then issues the a..h load, one
// round enable per cycle, the H += a..h update, and holds the digest-ready
// strobe until downstream takes it.
//
// Handshakes: a block transfers on a rising edge where blk_valid and
// blk_ready are both high. blk_ready is high only in IDLE when abort is low.
// dig_valid is held in DONE until a rising edge where dig_ready is high.

package sha;
    typedef enum logic [2:0] {
        SHA1   = 3'd0,
        SHA224 = 3'd1,
        SHA256 = 3'd2,
        SHA384 = 3'd3,
        SHA512 = 3'd4
    } mode_t;
endpackage

module sha_round_ctrl #(
    parameter int ROUNDS_256 = 64,
    parameter int ROUNDS_512 = 80,
    parameter int IDX_W      = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  sha::mode_t       mode,
    input  logic             blk_first,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic             abort,
    output logic             load_en,
    output logic             iv_sel,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             w_from_msg,
    output logic             h_upd,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             busy,
    output logic             err_mode,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ERR   = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_FINAL = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [IDX_W-1:0] LAST_256  = IDX_W'(ROUNDS_256 - 1);
    localparam logic [IDX_W-1:0] LAST_512  = IDX_W'(ROUNDS_512 - 1);
    localparam logic [IDX_W-1:0] MSG_WORDS = IDX_W'(16);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_last_idx;
    sha::mode_t       r_mode;
    logic             r_first;
    logic             w_accept;
    logic             w_round_last;

    assign w_accept     = blk_valid & blk_ready;
    // Round count comes from the mode latched at acceptance, never the live input.
    assign w_last_idx   = (r_mode == sha::SHA384 || r_mode == sha::SHA512) ? LAST_512 : LAST_256;
    assign w_round_last = (r_idx == w_last_idx);

    // Next-state decode; abort overrides accept, dig_ready and round advance.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_INIT:  w_next = S_IDLE;
                S_IDLE:  if (blk_valid) w_next = (mode == sha::SHA1) ? S_ERR : S_LOAD;
                S_ERR:   w_next = S_IDLE;
                S_LOAD:  w_next = S_ROUND;
                S_ROUND: if (w_round_last) w_next = S_FINAL;
                S_FINAL: w_next = S_DONE;
                S_DONE:  if (dig_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_INIT;
        else       r_state <= w_next;
    end

    // Round counter: advances only inside ROUND and wraps to 0 on leaving it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                           r_idx <= '0;
        else if (abort || r_state != S_ROUND || w_round_last) r_idx <= '0;
        else                                                 r_idx <= r_idx + 1'b1;
    end

    // Block attributes captured at acceptance and held for the whole block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode  <= sha::SHA256;
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= mode;
            r_first <= blk_first;
        end
    end

    assign blk_ready  = (r_state == S_IDLE) & ~abort;
    assign load_en    = (r_state == S_LOAD);
    assign iv_sel     = (r_state == S_LOAD) & r_first;
    assign round_en   = (r_state == S_ROUND);
    assign round_idx  = r_idx;
    assign w_from_msg = (r_state == S_ROUND) && (r_idx < MSG_WORDS);
    assign h_upd      = (r_state == S_FINAL);
    assign dig_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE) && (r_state != S_INIT);
    assign err_mode   = (r_state == S_ERR);
    assign dbg_state  = r_state;

endmodule
